// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the keypad calculator sequencer.
//   - state_e : FSM state encoding (IDLE=0 .. SHOW=5), also driven on the state port
//   - op_e    : selected arithmetic operation
//   - DEF_KEY_*: default key codes used as parameter defaults by calc_seq_ctl
//   - is_digit: true for key codes 0-9
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GOT_A  = 3'd1,
        ST_GOT_OP = 3'd2,
        ST_GOT_B  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_SHOW   = 3'd5
    } state_e;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam logic [3:0] DEF_KEY_ADD = 4'hA;
    localparam logic [3:0] DEF_KEY_SUB = 4'hB;
    localparam logic [3:0] DEF_KEY_EQ  = 4'hE;
    localparam logic [3:0] DEF_KEY_CLR = 4'hF;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/calc_seq_ctl_if.sv
// calc_seq_ctl_if: key-event input and display-side outputs of the calculator sequencer.
//   key/key_vld            : key code and single-cycle event strobe (from one_pulse)
//   opa/opb                : operands, BCD 0-9
//   res_tens/res_ones/neg  : result magnitude (BCD) and sign
//   busy/done              : execution in progress / one-cycle completion pulse
//   state                  : current FSM state encoding
// master: the key source / observer side.  slave: the sequencer.
interface calc_seq_ctl_if;
    logic [3:0] key;
    logic       key_vld;
    logic [3:0] opa;
    logic [3:0] opb;
    logic [3:0] res_tens;
    logic [3:0] res_ones;
    logic       neg;
    logic       busy;
    logic       done;
    logic [2:0] state;

    modport master (
        output key, key_vld,
        input  opa, opb, res_tens, res_ones, neg, busy, done, state
    );

    modport slave (
        input  key, key_vld,
        output opa, opb, res_tens, res_ones, neg, busy, done, state
    );
endinterface

// File: rtl/bcd2_updown.sv
// bcd2_updown: 2-digit BCD counter holding the result magnitude.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr_i                : clear to 00 (highest priority)
//   load_i, load_*_i     : load a BCD value
//   inc_i                : BCD increment, ones 9->0 carries into tens
//   dec_i                : BCD decrement (present only when CALC_SUB_EN is defined)
//   tens_o, ones_o       : current digits
//   zero_o               : magnitude is 00
// Macro CALC_SUB_EN: adds the dec_i port and the decrement path.
module bcd2_updown (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [3:0] load_tens_i,
    input  logic [3:0] load_ones_i,
    input  logic       inc_i,
`ifdef CALC_SUB_EN
    input  logic       dec_i,
`endif
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       zero_o
);

    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (load_i) begin
            tens_d = load_tens_i;
            ones_d = load_ones_i;
        end else if (inc_i) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
`ifdef CALC_SUB_EN
        else if (dec_i) begin
            if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = (tens_q == 4'd0) ? 4'd9 : tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;
    assign zero_o = (tens_q == 4'd0) && (ones_q == 4'd0);

endmodule

// File: rtl/calc_seq_ctl.sv
// calc_seq_ctl: keypad calculator sequencer between one_pulse and scan_ctl.
// Steps through operand A / operator / operand B / equals entry, then runs an
// iterative BCD add (or subtract) taking opb steps, and holds the result for display.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : calc_seq_ctl_if.slave (key events in, operands/result/status out)
// Macro CALC_SUB_EN: enables KEY_SUB, the subtract path and the neg output.
// Without it KEY_SUB is an ignored key, the operation is always add and neg is 0.
module calc_seq_ctl
    import calc_pkg::*;
#(
    parameter logic [3:0] KEY_ADD = DEF_KEY_ADD,
`ifdef CALC_SUB_EN
    parameter logic [3:0] KEY_SUB = DEF_KEY_SUB,
`endif
    parameter logic [3:0] KEY_EQ  = DEF_KEY_EQ,
    parameter logic [3:0] KEY_CLR = DEF_KEY_CLR
) (
    input  logic           clk,
    input  logic           rst_n,
    calc_seq_ctl_if.slave  bus
);

    state_e     state_q;
    logic [3:0] opa_q;
    logic [3:0] opb_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       done_q;
`ifdef CALC_SUB_EN
    op_e        op_q;
    logic       neg_q;
    logic       key_sub;
    logic       res_dec;
`endif

    logic       key_digit, key_op, key_eq, key_clr;
    logic       step;
    logic       res_clr, res_load, res_inc, res_zero;
    logic [3:0] res_tens, res_ones;

    // Key decode; anything that is not a digit or an enabled command code falls through.
    always_comb begin
        key_digit = bus.key_vld && is_digit(bus.key);
        key_eq    = bus.key_vld && (bus.key == KEY_EQ);
        key_clr   = bus.key_vld && (bus.key == KEY_CLR);
`ifdef CALC_SUB_EN
        key_sub   = bus.key_vld && (bus.key == KEY_SUB);
        key_op    = (bus.key_vld && (bus.key == KEY_ADD)) || key_sub;
`else
        key_op    = bus.key_vld && (bus.key == KEY_ADD);
`endif
    end

    // Result counter control. A step happens on every EXEC cycle with steps left;
    // clear wins, so an abort mid-EXEC discards the partial result.
    always_comb begin
        step     = (state_q == ST_EXEC) && (cnt_q != 4'd0) && !key_clr;
        res_clr  = key_clr || ((state_q == ST_SHOW) && key_digit);
        res_load = (state_q == ST_GOT_B) && key_eq;
`ifdef CALC_SUB_EN
        // Subtract counts the magnitude down to zero, then flips sign and counts up.
        res_dec  = step && (op_q == OP_SUB) && !neg_q && !res_zero;
        res_inc  = step && !res_dec;
`else
        res_inc  = step;
`endif
    end

    bcd2_updown u_res (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (res_clr),
        .load_i      (res_load),
        .load_tens_i (4'd0),
        .load_ones_i (opa_q),
        .inc_i       (res_inc),
`ifdef CALC_SUB_EN
        .dec_i       (res_dec),
`endif
        .tens_o      (res_tens),
        .ones_o      (res_ones),
        .zero_o      (res_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= 4'd0;
            opb_q   <= 4'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CALC_SUB_EN
            op_q    <= OP_ADD;
            neg_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (key_clr) begin
                state_q <= ST_IDLE;
                opa_q   <= 4'd0;
                opb_q   <= 4'd0;
                cnt_q   <= 4'd0;
                busy_q  <= 1'b0;
`ifdef CALC_SUB_EN
                op_q    <= OP_ADD;
                neg_q   <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (key_digit) begin
                            opa_q   <= bus.key;
                            state_q <= ST_GOT_A;
                        end
                    end
                    ST_GOT_A: begin
                        if (key_digit) begin
                            opa_q <= bus.key;
                        end else if (key_op) begin
`ifdef CALC_SUB_EN
                            op_q <= key_sub ? OP_SUB : OP_ADD;
`endif
                            state_q <= ST_GOT_OP;
                        end
                    end
                    ST_GOT_OP: begin
                        if (key_digit) begin
                            opb_q   <= bus.key;
                            state_q <= ST_GOT_B;
                        end
`ifdef CALC_SUB_EN
                        else if (key_op) begin
                            op_q <= key_sub ? OP_SUB : OP_ADD;
                        end
`endif
                    end
                    ST_GOT_B: begin
                        if (key_digit) begin
                            opb_q <= bus.key;
                        end else if (key_eq) begin
                            cnt_q   <= opb_q;
                            busy_q  <= 1'b1;
                            state_q <= ST_EXEC;
`ifdef CALC_SUB_EN
                            neg_q   <= 1'b0;
`endif
                        end
`ifdef CALC_SUB_EN
                        else if (key_op) begin
                            op_q <= key_sub ? OP_SUB : OP_ADD;
                        end
`endif
                    end
                    ST_EXEC: begin
                        if (cnt_q != 4'd0) begin
                            cnt_q <= cnt_q - 4'd1;
`ifdef CALC_SUB_EN
                            // Crossing zero while subtracting: sign flips on this step.
                            if ((op_q == OP_SUB) && !neg_q && res_zero) begin
                                neg_q <= 1'b1;
                            end
`endif
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_SHOW;
                        end
                    end
                    ST_SHOW: begin
                        if (key_digit) begin
                            opa_q   <= bus.key;
                            opb_q   <= 4'd0;
                            state_q <= ST_GOT_A;
`ifdef CALC_SUB_EN
                            neg_q   <= 1'b0;
`endif
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.opa      = opa_q;
    assign bus.opb      = opb_q;
    assign bus.res_tens = res_tens;
    assign bus.res_ones = res_ones;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.state    = state_q;
`ifdef CALC_SUB_EN
    assign bus.neg      = neg_q;
`else
    assign bus.neg      = 1'b0;
`endif

endmodule

// File: tb/tb_calc_seq_ctl.sv
// tb_calc_seq_ctl: directed test of calc_seq_ctl. Each KEY_EQ that should complete
// pushes its hand-computed result and completion cycle into a scoreboard queue; a
// monitor pops and compares whenever the DUT pulses done.
// Macro CALC_SUB_EN selects the subtract-build expectations.
module tb_calc_seq_ctl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    calc_seq_ctl_if bus ();

    calc_seq_ctl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int tens;
        int ones;
        int neg;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int errors    = 0;
    int checks    = 0;
    int done_cnt  = 0;
    int last_edge = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb res_tens", int'(bus.res_tens), e.tens);
                    chk("sb res_ones", int'(bus.res_ones), e.ones);
                    chk("sb neg", int'(bus.neg), e.neg);
                    chk("sb done cycle", cyc, e.done_cyc);
                    chk("sb state show", int'(bus.state), 5);
                    chk("sb busy low", int'(bus.busy), 0);
                    $display("done: res=%0d%0d neg=%0d at cycle %0d", bus.res_tens, bus.res_ones, bus.neg, cyc);
                end
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key     = k;
        bus.key_vld = 1'b1;
        last_edge   = cyc + 1;
        @(negedge clk);
        bus.key_vld = 1'b0;
        bus.key     = 4'h0;
    endtask

    // Press equals and expect done opb+1 cycles after the sampling edge.
    task automatic press_eq(input int tens, input int ones, input int neg, input int opb);
        exp_t e;
        press(4'hE);
        e.tens     = tens;
        e.ones     = ones;
        e.neg      = neg;
        e.done_cyc = last_edge + opb + 1;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int start;
        start = done_cnt;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start) break;
        end
        chk({name, " done seen"}, int'(done_cnt != start), 1);
    endtask

    task automatic chk_regs(input string name, input int st, input int a, input int b,
                            input int t, input int o);
        chk({name, " state"}, int'(bus.state), st);
        chk({name, " opa"}, int'(bus.opa), a);
        chk({name, " opb"}, int'(bus.opb), b);
        chk({name, " res_tens"}, int'(bus.res_tens), t);
        chk({name, " res_ones"}, int'(bus.res_ones), o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.key     = 4'h0;
        bus.key_vld = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk_regs("reset", 0, 0, 0, 0, 0);
        chk("reset neg", int'(bus.neg), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        rst_n = 1'b1;

        // 3 + 4 = 07, done 5 cycles after E
        press(4'd3); press(4'hA); press(4'd4);
        chk_regs("entry 3A4", 3, 3, 4, 0, 0);
        press_eq(0, 7, 0, 4);
        chk("add busy", int'(bus.busy), 1);
        chk("add state exec", int'(bus.state), 4);
        wait_done("add 3+4");
        @(negedge clk); #1;
        chk("done pulse width", int'(bus.done), 0);
        chk_regs("show hold", 5, 3, 4, 0, 7);

        // SHOW digit restarts entry; 9 + 9 = 18 with BCD carry
        press(4'd9);
        chk_regs("show digit 9", 1, 9, 0, 0, 0);
        press(4'hA); press(4'd9);
        press_eq(1, 8, 0, 9);
        wait_done("add 9+9");

        // Abort two cycles into EXEC
        press(4'd8); press(4'hA); press(4'd9);
        press(4'hE);
        repeat (2) @(negedge clk);
        chk("abort mid busy", int'(bus.busy), 1);
        chk("abort mid tens", int'(bus.res_tens), 1);
        chk("abort mid ones", int'(bus.res_ones), 0);
        press(4'hF);
        chk_regs("abort", 0, 0, 0, 0, 0);
        chk("abort busy", int'(bus.busy), 0);
        chk("abort neg", int'(bus.neg), 0);
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("abort no done", done_cnt, d0);
        chk("abort idle", int'(bus.state), 0);

        // Entry edits and ignored keys
        press(4'd1);  chk_regs("edit 1", 1, 1, 0, 0, 0);
        press(4'hE);  chk("edit E in GOT_A", int'(bus.state), 1);
        press(4'hC);  chk("edit C in GOT_A", int'(bus.state), 1);
        press(4'd5);  chk("edit opa overwrite", int'(bus.opa), 5);
        press(4'hA);  chk("edit A", int'(bus.state), 2);
        press(4'hE);  chk("edit E in GOT_OP", int'(bus.state), 2);
        press(4'hD);  chk("edit D in GOT_OP", int'(bus.state), 2);
        press(4'hB);  chk("edit B in GOT_OP", int'(bus.state), 2);
        press(4'd3);  chk_regs("edit 3", 3, 5, 3, 0, 0);
        press(4'd6);  chk_regs("edit opb overwrite", 3, 5, 6, 0, 0);
        press(4'hC);  chk("edit C in GOT_B", int'(bus.state), 3);
`ifdef CALC_SUB_EN
        press_eq(0, 1, 1, 6);
`else
        press_eq(1, 1, 0, 6);
`endif
        wait_done("edit 5op6");

`ifdef CALC_SUB_EN
        press(4'd2); press(4'hB); press(4'd5);
        press_eq(0, 3, 1, 5);
        wait_done("sub 2-5");
        press(4'd7); press(4'hB); press(4'd7);
        press_eq(0, 0, 0, 7);
        wait_done("sub 7-7");
`else
        press(4'd2);
        press(4'hB);
        chk("B ignored in GOT_A", int'(bus.state), 1);
        press(4'hA); press(4'd5);
        press_eq(0, 7, 0, 5);
        wait_done("add 2+5");
`endif

        // SHOW digit 4
        press(4'd4);
        chk_regs("show digit 4", 1, 4, 0, 0, 0);

        // Asynchronous reset mid-EXEC
        press(4'hA); press(4'd9);
        press(4'hE);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_regs("async reset", 0, 0, 0, 0, 0);
        chk("async reset busy", int'(bus.busy), 0);
        chk("async reset neg", int'(bus.neg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("post reset no done", done_cnt, d0);
        chk("post reset idle", int'(bus.state), 0);

        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
